ntt_job_controller: RTL and testbench
=====================================

# ntt_job_controller

Sequences one complete NTT job on `ntt_processor`. It streams 2048 packed 60-bit coefficient words from a valid/ready source into the processor's load port. It then issues the start pulse, supervises the run with a timeout, and frames the result burst for the downstream collector. It sits between the host DMA/stream fabric and one `ntt_processor` instance; one controller serves one processor.

## Interface
Parameters:
- `LOG_CORE_COUNT`, 5: must match the processor; sets output beats `OUT_BEATS = 1 << (10 - LOG_CORE_COUNT)` (32 at default).
- `LOAD_WORDS`, 2048: words per job, addressed 0..LOAD_WORDS-1 on `ntt_address_in`.
- `SETTLE_CYCLES`, 2: idle cycles between the last load write and `ntt_start`.
- `RUN_TIMEOUT`, 4096: maximum cycles from `ntt_start` to first `ntt_output_active`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cmd_start` in 1: single-cycle job request; honoured only in IDLE or ERR.
- `cmd_abort` in 1: abort; honoured only in LOAD and SETTLE.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 60, `s_last` in 1: coefficient stream.
- `ntt_write_enable` out 1, `ntt_address_in` out 11, `ntt_data_in` out 60: processor load port.
- `ntt_start` out 1: processor start pulse.
- `ntt_output_active` in 1, `ntt_address_out` in 9: processor output framing.
- `out_valid` out 1: a result beat is on the processor `out` bus this cycle.
- `out_first` out 1, `out_last` out 1: beat markers.
- `busy` out 1: high in every state except IDLE and ERR.
- `done` out 1: one-cycle job-complete pulse.
- `err` out 1, `err_code` out 2: 1 = framing, 2 = run timeout, 3 = beat-count mismatch; sticky until the next accepted `cmd_start`.
- `run_latency` out 16: cycles from `ntt_start` to first output beat, saturating, latched per job.

## Operation
States: IDLE, LOAD, SETTLE, START, RUN, DRAIN, DONE, ERR.
- IDLE → LOAD on `cmd_start`: load address cleared, `err`/`err_code` cleared.
- LOAD:
  - `s_ready` = 1. Each handshake writes `s_data` to the current address, then increments the address.
  - Word LOAD_WORDS-1 accepted with `s_last` = 1 → SETTLE.
  - `s_last` = 1 on any earlier word, or `s_last` = 0 on the final word → ERR, code 1. The offending word is still written.
- SETTLE: counts SETTLE_CYCLES with `ntt_write_enable` = 0, then → START.
- START: `ntt_start` = 1 for exactly one cycle, latency counter cleared → RUN.
- RUN:
  - Latency counter increments each cycle.
  - First cycle with `ntt_output_active` = 1 → DRAIN: latch `run_latency`, assert the first beat.
  - Counter reaches RUN_TIMEOUT → ERR, code 2.
- DRAIN:
  - `out_valid` mirrors `ntt_output_active`; beat counter increments per beat.
  - `ntt_output_active` falls → DONE if beats == OUT_BEATS, else ERR code 3.
  - No backpressure exists: the processor cannot stall, and the collector must accept every beat.
- DONE: `done` = 1 for one cycle → IDLE.
- ERR: `err` = 1; `cmd_start` restarts a job exactly as from IDLE.
- `cmd_abort` in LOAD/SETTLE → IDLE, no error. It is ignored in START/RUN/DRAIN because the processor has no abort.
- `cmd_start` while `busy` is ignored.
- Simultaneous `cmd_abort` and a final-word handshake: the abort wins and the word is not written.

## Timing
- All outputs are registered. Reset values: every output 0, `s_ready` 0, state IDLE.
- Stream handshake at edge k → `ntt_write_enable` = 1, with address and data, during cycle k+1. No handshake → `ntt_write_enable` = 0 in the following cycle.
- After `cmd_start` at edge k, `s_ready` = 1 from cycle k+1.
- Back-to-back handshakes give one write per cycle; a gap in `s_valid` gives a gap in writes. Address never skips.
- `out_valid`, `out_first` and `out_last` are combinational from `ntt_output_active` gated by state DRAIN/RUN, so they are zero-latency, aligned with the processor `out` bus. This is the one exception to registered outputs.
- `out_first` is high on beat 0 only. `out_last` is high when `ntt_address_out` == OUT_BEATS-1.
- `done` is asserted the cycle after `ntt_output_active` falls.
- `rst_n` low at any point, including mid-RUN, forces IDLE and zeroes all outputs immediately. The processor is not reset, so the bench must wait for it to return to standby.

## Test plan
- Nominal job: 2048 words at full rate with `s_last` on word 2047; model asserts output_active 600 cycles after start for 32 cycles → `ntt_address_in` 0..2047 in order, one `ntt_start` pulse 3 cycles after the last write, 32 `out_valid` beats, `run_latency` = 600, `done` pulse.
- Throttled stream: random `s_valid` at 30% duty → identical written address/data sequence, no duplicated or missing addresses.
- Framing error: `s_last` on word 100 → ERR, `err_code` = 1, no `ntt_start`. A following `cmd_start` clears `err` and a nominal job completes.
- Timeout: model never raises output_active → `err_code` = 2 exactly RUN_TIMEOUT cycles after `ntt_start`.
- Short burst: output_active held for only 31 cycles → `err_code` = 3, no `done`.
- Abort and reset: `cmd_abort` at word 500 → IDLE, `err` = 0. `rst_n` pulse mid-RUN → all outputs 0 asynchronously. `cmd_start` during RUN is ignored.

Source files
------------

// File: rtl/ntt_job_if.sv
// ntt_job_if: every signal between the job controller, the host command and
// coefficient stream, and the ntt_processor load/start/output-framing ports.
//
// Stream handshake: a word transfers on each rising clk edge where s_valid and
// s_ready are both high, and s_data/s_last belong to that word. s_ready is a
// registered output and is high only while the controller is loading. A
// source that holds s_valid with s_ready low keeps s_data/s_last stable until
// the transfer. The result burst has no handshake: out_valid marks a beat the
// collector must take in that same cycle.
interface ntt_job_if;
    logic        cmd_start;
    logic        cmd_abort;
    logic        s_valid;
    logic        s_ready;
    logic [59:0] s_data;
    logic        s_last;
    logic        ntt_write_enable;
    logic [10:0] ntt_address_in;
    logic [59:0] ntt_data_in;
    logic        ntt_start;
    logic        ntt_output_active;
    logic [8:0]  ntt_address_out;
    logic        out_valid;
    logic        out_first;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] run_latency;

    // Controller view.
    modport slave (
        input  cmd_start, cmd_abort, s_valid, s_data, s_last,
               ntt_output_active, ntt_address_out,
        output s_ready, ntt_write_enable, ntt_address_in, ntt_data_in,
               ntt_start, out_valid, out_first, out_last,
               busy, done, err, err_code, run_latency
    );

    // Host, stream source and processor view.
    modport master (
        output cmd_start, cmd_abort, s_valid, s_data, s_last,
               ntt_output_active, ntt_address_out,
        input  s_ready, ntt_write_enable, ntt_address_in, ntt_data_in,
               ntt_start, out_valid, out_first, out_last,
               busy, done, err, err_code, run_latency
    );
endinterface

// File: rtl/ntt_job_controller.sv
// ntt_job_controller: loads one job of packed coefficients into an
// ntt_processor, pulses its start, watches the run for a timeout and frames
// the result burst for the downstream collector.
module ntt_job_controller #(
    parameter int LOG_CORE_COUNT = 5,
    parameter int LOAD_WORDS     = 2048,
    parameter int SETTLE_CYCLES  = 2,
    parameter int RUN_TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    ntt_job_if.slave   bus,
    output logic [2:0] dbg_state_o
);
    localparam int          OUT_BEATS    = 1 << (10 - LOG_CORE_COUNT);
    localparam logic [10:0] LAST_ADDR    = 11'(LOAD_WORDS - 1);
    localparam logic [8:0]  LAST_BEAT    = 9'(OUT_BEATS - 1);
    localparam logic [11:0] BEATS_EXP    = 12'(OUT_BEATS);
    localparam logic [7:0]  SETTLE_END   = 8'(SETTLE_CYCLES);
    localparam logic [15:0] TIMEOUT_LAST = 16'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        START  = 3'd3,
        RUN    = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] load_ptr_q, load_ptr_d;
    logic        we_q, we_d;
    logic [10:0] wr_addr_q, wr_addr_d;
    logic [59:0] wr_data_q, wr_data_d;
    logic [7:0]  settle_q, settle_d;
    logic [15:0] lat_q, lat_d;
    logic [15:0] run_lat_q, run_lat_d;
    logic [11:0] beat_q, beat_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        s_ready_q, start_q, busy_q, done_q, err_q;
    logic        hs;
    logic        in_burst;

    assign hs = bus.s_valid && s_ready_q;

    // Next-state logic: load sequencing, settle/start timing, run supervision, burst framing.
    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        we_d       = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        settle_d   = settle_q;
        lat_d      = lat_q;
        run_lat_d  = run_lat_q;
        beat_d     = beat_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE, ERR: begin
                if (bus.cmd_start) begin
                    state_d    = LOAD;
                    load_ptr_d = '0;
                    err_code_d = 2'd0;
                end
            end
            LOAD: begin
                // An abort beats any handshake in the same cycle, so that word is dropped.
                if (bus.cmd_abort) begin
                    state_d = IDLE;
                end else if (hs) begin
                    we_d       = 1'b1;
                    wr_addr_d  = load_ptr_q;
                    wr_data_d  = bus.s_data;
                    load_ptr_d = load_ptr_q + 11'd1;
                    if (load_ptr_q == LAST_ADDR) begin
                        if (bus.s_last) begin
                            state_d  = SETTLE;
                            settle_d = '0;
                        end else begin
                            state_d    = ERR;
                            err_code_d = 2'd1;
                        end
                    end else if (bus.s_last) begin
                        state_d    = ERR;
                        err_code_d = 2'd1;
                    end
                end
            end
            SETTLE: begin
                // First SETTLE cycle carries the final write; SETTLE_CYCLES quiet cycles follow.
                if (bus.cmd_abort) begin
                    state_d = IDLE;
                end else if (settle_q == SETTLE_END) begin
                    state_d = START;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            START: begin
                // Counter holds cycles elapsed since the start pulse cycle.
                state_d = RUN;
                lat_d   = 16'd1;
            end
            RUN: begin
                if (bus.ntt_output_active) begin
                    state_d   = DRAIN;
                    run_lat_d = lat_q;
                    beat_d    = 12'd1;
                end else if (lat_q >= TIMEOUT_LAST) begin
                    state_d    = ERR;
                    err_code_d = 2'd2;
                end else if (lat_q != 16'hFFFF) begin
                    lat_d = lat_q + 16'd1;
                end
            end
            DRAIN: begin
                if (bus.ntt_output_active) begin
                    if (beat_q != 12'hFFF) beat_d = beat_q + 12'd1;
                end else if (beat_q == BEATS_EXP) begin
                    state_d = DONE;
                end else begin
                    state_d    = ERR;
                    err_code_d = 2'd3;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops every output to zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            load_ptr_q <= '0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            settle_q   <= '0;
            lat_q      <= '0;
            run_lat_q  <= '0;
            beat_q     <= '0;
            err_code_q <= '0;
            s_ready_q  <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            we_q       <= we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            settle_q   <= settle_d;
            lat_q      <= lat_d;
            run_lat_q  <= run_lat_d;
            beat_q     <= beat_d;
            err_code_q <= err_code_d;
            s_ready_q  <= (state_d == LOAD);
            start_q    <= (state_d == START);
            busy_q     <= (state_d != IDLE) && (state_d != ERR);
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERR);
        end
    end

    // Burst markers ride the processor output bus with zero latency.
    assign in_burst      = (state_q == RUN) || (state_q == DRAIN);
    assign bus.out_valid = bus.ntt_output_active && in_burst;
    assign bus.out_first = bus.ntt_output_active && (state_q == RUN);
    assign bus.out_last  = bus.out_valid && (bus.ntt_address_out == LAST_BEAT);

    assign bus.s_ready          = s_ready_q;
    assign bus.ntt_write_enable = we_q;
    assign bus.ntt_address_in   = wr_addr_q;
    assign bus.ntt_data_in      = wr_data_q;
    assign bus.ntt_start        = start_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.err              = err_q;
    assign bus.err_code         = err_code_q;
    assign bus.run_latency      = run_lat_q;
    assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_ntt_job_controller.sv
// tb_ntt_job_controller: table of whole-job scenarios plus hand-written
// sequences for asynchronous reset mid-run and commands ignored while busy.
module tb_ntt_job_controller;
    localparam int RUN_TIMEOUT = 4096;
    localparam int OUT_BEATS   = 32;

    typedef struct {
        string      name;
        int         n_send;       // words offered on the stream
        int         last_pos;     // word index carrying s_last, -1 for none
        int         duty;         // s_valid duty in percent
        int         abort_at;     // word offered together with cmd_abort, -1 for none
        int         delay;        // processor cycles from start to first beat, -1 never
        int         beats;        // processor burst length
        int         exp_writes;
        logic [1:0] exp_code;
        logic [2:0] exp_state;
        int         exp_done;
        int         exp_starts;
        int         exp_beats;
        int         exp_latency;
    } job_t;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ntt_job_if  bus ();
    logic [2:0] dbg_state;

    ntt_job_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Scoreboard and observation counters
    logic [70:0] exp_q[$];
    logic [70:0] exp_w;
    int n_cmp = 0;
    int n_bad = 0;
    int wr_prints = 0;
    int cyc = 0;
    int wr_cnt = 0, start_cnt = 0, beat_cnt = 0, first_cnt = 0, last_cnt = 0, done_cnt = 0;
    int last_we_cyc = 0, start_cyc = 0, last_beat_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic err_prev = 1'b0;
    int model_delay;
    int model_beats;
    logic model_busy;
    job_t tbl[11];

    function automatic logic [59:0] data_of(input int i);
        return {28'(i ^ 32'h05A5_A5A5), 32'(i) * 32'h9E37_79B1};
    endfunction

    function automatic logic [127:0] outs_vec();
        return 128'({bus.s_ready, bus.ntt_write_enable, bus.ntt_address_in, bus.ntt_data_in,
                     bus.ntt_start, bus.out_valid, bus.out_first, bus.out_last, bus.busy,
                     bus.done, bus.err, bus.err_code, bus.run_latency});
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: write scoreboard and event timestamps, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.ntt_write_enable === 1'b1) begin
                wr_cnt++;
                last_we_cyc = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    wr_prints++;
                    if (wr_prints <= 40)
                        $display("FAIL write_unexpected: got write addr %0d, required no write", bus.ntt_address_in);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({bus.ntt_address_in, bus.ntt_data_in} !== exp_w) begin
                        n_bad++;
                        wr_prints++;
                        if (wr_prints <= 40)
                            $display("FAIL write: got addr %0d data 0x%0h, required addr %0d data 0x%0h",
                                     bus.ntt_address_in, bus.ntt_data_in, exp_w[70:60], exp_w[59:0]);
                    end
                end
            end
            if (bus.ntt_start === 1'b1) begin start_cnt++; start_cyc = cyc; end
            if (bus.out_valid === 1'b1) begin beat_cnt++; last_beat_cyc = cyc; end
            if (bus.out_first === 1'b1) first_cnt++;
            if (bus.out_last === 1'b1) last_cnt++;
            if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (bus.err === 1'b1 && !err_prev) err_cyc = cyc;
            err_prev = (bus.err === 1'b1);
        end
    end

    // Processor model: after a start pulse, waits model_delay cycles, then
    // drives a burst of model_beats beats with ascending output addresses.
    initial begin
        bus.ntt_output_active = 1'b0;
        bus.ntt_address_out   = '0;
        model_busy            = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ntt_start === 1'b1 && model_delay >= 0) begin
                model_busy = 1'b1;
                repeat (model_delay) @(posedge clk);
                #1;
                for (int b = 0; b < model_beats; b++) begin
                    bus.ntt_output_active = 1'b1;
                    bus.ntt_address_out   = 9'(b);
                    @(posedge clk);
                    #1;
                end
                bus.ntt_output_active = 1'b0;
                bus.ntt_address_out   = '0;
                model_busy = 1'b0;
            end
        end
    end

    // Driver: command pulse, then the coefficient stream with optional abort.
    task automatic load_stream(input job_t j);
        int   i = 0;
        int   guard = 0;
        logic v;
        logic hs;
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        check($sformatf("%s.s_ready_after_start", j.name), bus.s_ready, 1);
        check($sformatf("%s.err_cleared", j.name), {bus.err, bus.err_code}, 0);
        while (i < j.n_send && guard < 50000) begin
            v = (j.duty >= 100) || (int'($urandom_range(0, 99)) < j.duty);
            bus.s_valid = v;
            bus.s_data  = data_of(i);
            bus.s_last  = (i == j.last_pos);
            hs = v && (bus.s_ready === 1'b1);
            @(negedge clk);
            guard++;
            if (hs) i++;
        end
        if (guard >= 50000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.stream_stalled: got %0d words accepted, required %0d", j.name, i, j.n_send);
        end
        if (j.abort_at >= 0) begin
            bus.cmd_abort = 1'b1;
            bus.s_valid   = 1'b1;
            bus.s_data    = data_of(j.abort_at);
            bus.s_last    = (j.abort_at == j.last_pos);
            @(negedge clk);
            bus.cmd_abort = 1'b0;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({11'(i), data_of(i)});
    endtask

    task automatic wait_model(input string name);
        int g = 0;
        while (model_busy && g < 6000) begin @(negedge clk); g++; end
        check($sformatf("%s.model_idle", name), model_busy, 0);
    endtask

    // One complete job from the table, checked against the row's expectations.
    task automatic run_job(input job_t j);
        int b_wr, b_st, b_bt, b_fi, b_la, b_dn;
        int g = 0;
        model_delay = j.delay;
        model_beats = j.beats;
        b_wr = wr_cnt; b_st = start_cnt; b_bt = beat_cnt;
        b_fi = first_cnt; b_la = last_cnt; b_dn = done_cnt;
        push_writes(j.exp_writes);
        load_stream(j);
        while (bus.busy === 1'b1 && g < 12000) begin @(negedge clk); g++; end
        check($sformatf("%s.busy_released", j.name), bus.busy, 0);
        wait_model(j.name);
        repeat (2) @(negedge clk);
        check($sformatf("%s.writes", j.name), wr_cnt - b_wr, j.exp_writes);
        check($sformatf("%s.writes_missing", j.name), exp_q.size(), 0);
        exp_q.delete();
        check($sformatf("%s.state", j.name), dbg_state, j.exp_state);
        check($sformatf("%s.err", j.name), bus.err, (j.exp_code != 2'd0));
        check($sformatf("%s.err_code", j.name), bus.err_code, j.exp_code);
        check($sformatf("%s.done_pulses", j.name), done_cnt - b_dn, j.exp_done);
        check($sformatf("%s.start_pulses", j.name), start_cnt - b_st, j.exp_starts);
        check($sformatf("%s.beats", j.name), beat_cnt - b_bt, j.exp_beats);
        check($sformatf("%s.first_marks", j.name), first_cnt - b_fi, (j.exp_beats > 0) ? 1 : 0);
        check($sformatf("%s.last_marks", j.name), last_cnt - b_la, (j.exp_beats == OUT_BEATS) ? 1 : 0);
        if (j.exp_starts > 0)
            check($sformatf("%s.start_after_last_write", j.name), start_cyc - last_we_cyc, 3);
        if (j.exp_beats > 0)
            check($sformatf("%s.run_latency", j.name), bus.run_latency, j.exp_latency);
        if (j.exp_done > 0)
            check($sformatf("%s.done_after_last_beat", j.name), done_cyc - last_beat_cyc, 2);
        if (j.exp_code == 2'd2)
            check($sformatf("%s.timeout_cycles", j.name), err_cyc - start_cyc, RUN_TIMEOUT);
    endtask

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_st, b_bt, b_dn;
        int g;
        rst_n         = 1'b0;
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        model_delay   = -1;
        model_beats   = 0;

        tbl[0]  = '{"nominal",            2048, 2047, 100,   -1,  600, 32, 2048, 2'd0, 3'd0, 1, 1, 32,  600};
        tbl[1]  = '{"throttled_30pct",    2048, 2047,  30,   -1,  600, 32, 2048, 2'd0, 3'd0, 1, 1, 32,  600};
        tbl[2]  = '{"framing_last_at_100", 101,  100, 100,   -1,  600, 32,  101, 2'd1, 3'd7, 0, 0,  0,    0};
        tbl[3]  = '{"restart_after_err",  2048, 2047, 100,   -1,   37, 32, 2048, 2'd0, 3'd0, 1, 1, 32,   37};
        tbl[4]  = '{"run_timeout",        2048, 2047, 100,   -1,   -1,  0, 2048, 2'd2, 3'd7, 0, 1,  0,    0};
        tbl[5]  = '{"short_burst_31",     2048, 2047, 100,   -1,  600, 31, 2048, 2'd3, 3'd7, 0, 1, 31,  600};
        tbl[6]  = '{"no_last_on_final",   2048,   -1, 100,   -1,  600, 32, 2048, 2'd1, 3'd7, 0, 0,  0,    0};
        tbl[7]  = '{"abort_at_500",        500,   -1, 100,  500,  600, 32,  500, 2'd0, 3'd0, 0, 0,  0,    0};
        tbl[8]  = '{"abort_on_final",     2047, 2047, 100, 2047,  600, 32, 2047, 2'd0, 3'd0, 0, 0,  0,    0};
        tbl[9]  = '{"latency_one",        2048, 2047, 100,   -1,    1, 32, 2048, 2'd0, 3'd0, 1, 1, 32,    1};
        tbl[10] = '{"latency_at_limit",   2048, 2047, 100,   -1, 4095, 32, 2048, 2'd0, 3'd0, 1, 1, 32, 4095};

        #1;
        check("reset.outputs", outs_vec(), 0);
        check("reset.state", dbg_state, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.outputs", outs_vec(), 0);

        foreach (tbl[k]) run_job(tbl[k]);

        // cmd_start during RUN is ignored; reset mid-RUN zeroes outputs at once.
        model_delay = 600;
        model_beats = 32;
        b_st = start_cnt; b_bt = beat_cnt; b_dn = done_cnt;
        push_writes(2048);
        load_stream(tbl[0]);
        g = 0;
        while (start_cnt == b_st && g < 100) begin @(negedge clk); g++; end
        check("midrun.start_seen", start_cnt - b_st, 1);
        repeat (50) @(negedge clk);
        check("midrun.state_run", dbg_state, 3'd4);
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        check("midrun.start_ignored_state", dbg_state, 3'd4);
        check("midrun.start_ignored_ready", bus.s_ready, 0);
        check("midrun.busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun.async_reset_outputs", outs_vec(), 0);
        check("midrun.async_reset_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_model("midrun");
        repeat (2) @(negedge clk);
        check("midrun.writes_missing", exp_q.size(), 0);
        exp_q.delete();
        check("midrun.no_beats_after_reset", beat_cnt - b_bt, 0);
        check("midrun.no_done", done_cnt - b_dn, 0);
        check("midrun.single_start", start_cnt - b_st, 1);
        check("midrun.idle_outputs", outs_vec(), 0);

        // A full job after the processor returns to standby.
        run_job(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
